debounce_filter: RTL and testbench
==================================

// Module: debounce_filter
// PURPOSE
//   Per-bit debounce/glitch filter for Size asynchronous, mechanically bouncing inputs (push buttons, switches).
//   Output bit follows its input only after the input has held a new level for FilterPeriod_ns of Clock.
//   Sits between board pins and control logic; one instance serves a whole button bank.
// PARAMETERS
//   Size            2       number of independent input/output channels
//   ClockPeriod_ns  20      Clock period in ns; used only to derive the filter count
//   FilterPeriod_ns 70_000  required stable time in ns before an output changes
//   ResetValue      '1      O value after reset (default: idle-high, active-low buttons)
// PORTS
//   Clock  in   1     system clock; all state updates on rising edge
//   Reset  in   1     asynchronous, active-high reset
//   I      in   Size  raw inputs
//   O      out  Size  filtered outputs, registered
// BEHAVIOUR
//   - N = max(1, ceil(FilterPeriod_ns/ClockPeriod_ns)); the defaults give N = 3500.
//   - Count width = $clog2(N+1). Computation is elaboration-time only.
//   - Reset asserted (asynchronously): every O bit = ResetValue bit and every counter = 0.
//   - Reset is released synchronously by the user; no internal reset synchronizer is provided.
//   - Each bit is independent. S is the sampled input bit (I directly, or the synchronizer output when FILTER_SYNC_EN is defined).
//   - Each rising edge:
//     - S == O: counter <= 0, O holds.
//     - S != O and counter == N-1: O <= S and counter <= 0, both on the same edge.
//     - S != O otherwise: counter <= counter + 1.
//   - O therefore changes on the Nth consecutive edge at which S differs from O (latency N cycles).
//   - Any sample equal to O before then restarts the count. A glitch shorter than N cycles never reaches O.
//   - Both directions (0->1 and 1->0) are filtered identically.
//   - The counter never wraps: it is bounded by N-1.
//   - Reset during a count discards it; counting restarts from 0 after release.
//   - Simultaneous changes on several bits are handled independently, with no cross-bit interaction.
// CONFIGURATION
//   FILTER_SYNC_EN defined:
//     - Each I bit passes through a 2-flop synchronizer before the counter logic.
//     - Synchronizer flops reset to ResetValue.
//     - Total latency is N+2 cycles.
//   FILTER_SYNC_EN undefined:
//     - S = I directly, and I is required to be synchronous to Clock.
//     - Latency is exactly N cycles.
// STRUCTURE
//   - filter_pkg holds a function filter_count(clk_ns, filt_ns) returning N.
//   - filter_pkg also holds a function returning the count width.
//   - Sub-module debounce_filter_bit: one channel (optional synchronizer, counter, output flop).
//   - The top instantiates debounce_filter_bit Size times in a generate loop.
// TESTING (defaults, Clock 20 ns, N = 3500 → 70 us; FILTER_SYNC_EN undefined)
//   1. I='1 through reset -> O='1 and stays '1 for 140 us.
//   2. At t0 I='b01 -> O[1] falls on the 3500th rising edge after t0 (~t0+70 us); O[0] stays 1.
//   3. I back to 'b11 for 140 us -> O returns to 'b11 about 70 us later.
//   4. After 75 us at 'b11, I='b00 -> both O bits fall together ~70 us later.
//   5. I[0] glitches low for 3499 cycles then returns high -> O[0] never changes, and a following 3500-cycle low is accepted.
//   6. Assert Reset midway through a count (e.g. cycle 2000) -> O=ResetValue immediately and the full 3500 cycles are needed after release.

Source files
------------

// File: rtl/filter_pkg.sv
// Elaboration-time helpers for debounce_filter: filter count N and counter width.
package filter_pkg;

  // N = max(1, ceil(filt_ns / clk_ns))
  function automatic int filter_count(input int clk_ns, input int filt_ns);
    int n;
    n = (filt_ns + clk_ns - 1) / clk_ns;
    if (n < 1) begin
      n = 1;
    end else begin
      n = n;
    end
    return n;
  endfunction

  function automatic int filter_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_filter_bit.sv
// One debounce channel: optional 2-flop synchronizer (FILTER_SYNC_EN), stability counter, output flop.
module debounce_filter_bit #(
  parameter int   N       = 3500,
  parameter int   W       = 12,
  parameter logic RST_VAL = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic I,
  output logic O
);

  localparam logic [W-1:0] C_LAST = W'(N - 1);

  logic         w_s;
  logic         r_o;
  logic [W-1:0] r_cnt;

`ifdef FILTER_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchronizer for pins that are asynchronous to Clock
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync <= {2{RST_VAL}};
    end else begin
      r_sync <= {r_sync[0], I};
    end
  end

  assign w_s = r_sync[1];
`else
  assign w_s = I;
`endif

  // Output flips only after N consecutive edges of disagreement
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_o   <= RST_VAL;
      r_cnt <= {W{1'b0}};
    end else if (w_s == r_o) begin
      r_cnt <= {W{1'b0}};
    end else if (r_cnt == C_LAST) begin
      r_o   <= w_s;
      r_cnt <= {W{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign O = r_o;

endmodule

// File: rtl/debounce_filter.sv
// Bank of independent debounce channels; define FILTER_SYNC_EN to add input synchronizers.
module debounce_filter
  import filter_pkg::*;
#(
  parameter int              Size            = 2,
  parameter int              ClockPeriod_ns  = 20,
  parameter int              FilterPeriod_ns = 70_000,
  parameter logic [Size-1:0] ResetValue      = '1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [Size-1:0] I,
  output logic [Size-1:0] O
);

  localparam int N = filter_count(ClockPeriod_ns, FilterPeriod_ns);
  localparam int W = filter_width(N);

  for (genvar g = 0; g < Size; g++) begin : g_bit
    debounce_filter_bit #(
      .N      (N),
      .W      (W),
      .RST_VAL(ResetValue[g])
    ) u_bit (
      .Clock(Clock),
      .Reset(Reset),
      .I    (I[g]),
      .O    (O[g])
    );
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter (defaults, no synchronizer) with a run-length reference model.
module tb_debounce_filter;

  localparam int N = (70_000 + 20 - 1) / 20;

  logic       Clock;
  logic       Reset;
  logic [1:0] I;
  logic [1:0] O;

  int checks = 0;
  int errors = 0;

  debounce_filter dut (
    .Clock(Clock),
    .Reset(Reset),
    .I    (I),
    .O    (O)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  // Model: a bit adopts its input once that input has held one level for N
  // post-reset edges while differing from the current output.
  logic [1:0] m_o;
  logic [1:0] prev_s;
  int         run [2];
  bit         fresh;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_o    = 2'b11;
      run[0] = 0;
      run[1] = 0;
      fresh  = 1'b1;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (fresh || (I[b] != prev_s[b])) run[b] = 1;
        else                              run[b] = run[b] + 1;
        if ((I[b] != m_o[b]) && (run[b] >= N)) m_o[b] = I[b];
      end
      prev_s = I;
      fresh  = 1'b0;
    end
  end

  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: O=%b expected %b", name, $time, act, exp);
    end
  endtask

  // Advance n cycles, checking the DUT against the model at every falling edge
  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      cmp("model", O, m_o);
    end
  endtask

  initial begin
    Reset = 1'b1;
    I     = 2'b11;
    #1;
    cmp("reset_async", O, 2'b11);
    cycles(3);
    cmp("reset_hold", O, 2'b11);
    Reset = 1'b0;

    // 1: idle high stays high
    cycles(2 * N);
    cmp("idle_high", O, 2'b11);

    // 2: bit1 falls on the Nth edge
    I = 2'b01;
    cycles(N - 1);
    cmp("fall_before", O, 2'b11);
    cycles(1);
    cmp("fall_at_n", O, 2'b01);
    cycles(100);
    cmp("fall_hold", O, 2'b01);

    // 3: bit1 rises back
    I = 2'b11;
    cycles(N - 1);
    cmp("rise_before", O, 2'b01);
    cycles(1);
    cmp("rise_at_n", O, 2'b11);
    cycles(N);

    // 4: both bits fall together
    cycles(250);
    I = 2'b00;
    cycles(N - 1);
    cmp("both_before", O, 2'b11);
    cycles(1);
    cmp("both_at_n", O, 2'b00);

    // 5: N-1 cycle glitch on bit0 is rejected, N cycle low accepted
    I = 2'b11;
    cycles(N);
    cmp("restore_high", O, 2'b11);
    I = 2'b10;
    cycles(N - 1);
    cmp("glitch_peak", O, 2'b11);
    I = 2'b11;
    cycles(N);
    cmp("glitch_reject", O, 2'b11);
    I = 2'b10;
    cycles(N - 1);
    cmp("low_before", O, 2'b11);
    cycles(1);
    cmp("low_accept", O, 2'b10);

    // 6: reset mid-count discards progress
    I = 2'b01;
    cycles(2000);
    Reset = 1'b1;
    #1;
    cmp("reset_mid", O, 2'b11);
    cycles(2);
    Reset = 1'b0;
    cycles(N - 1);
    cmp("post_reset_before", O, 2'b11);
    cycles(1);
    cmp("post_reset_at_n", O, 2'b01);
    cycles(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
